data_mem_responder: RTL and testbench
=====================================

# data_mem_responder

Data-memory responder for the RV32I core: the target end of the control unit's load/store requests. It accepts one byte/half/word access per handshake and performs it against an internal little-endian word array. Misaligned accesses are split into two word beats, with optional wait states. Load results are returned sign- or zero-extended as selected by funct3.

## Interface
- DEPTH_WORDS, 1024: words of storage; valid byte addresses 0 .. 4*DEPTH_WORDS-1
- LATENCY, 1: wait cycles inserted before each word beat (0..15)

- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high
- req  in  1  request valid; sampled only in IDLE
- we  in  1  1 = store, 0 = load
- addr  in  32  byte address
- wdata  in  32  store data, low bytes used per size
- mem_size  in  2  insn[13:12]: 00 byte, 01 half, 10 word, 11 illegal
- mem_extend  in  3  insn[14:12]: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; others illegal for loads, ignored for stores
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle completion pulse
- rdata  out  32  extended load data; valid while done, held until next accept
- fault  out  1  qualifies done: request rejected, no memory effect

## Operation
- States: IDLE, BEAT0, BEAT1, RESP.
- IDLE, req=1: capture we/addr/wdata/size/extend; off = addr[1:0]; nbytes = 1/2/4; split = (off + nbytes > 4); w0 = addr[31:2], w1 = w0+1; load counter with LATENCY.
- Fault is decided at accept:
  - mem_size=11;
  - load with illegal mem_extend;
  - w0 >= DEPTH_WORDS;
  - split and w1 >= DEPTH_WORDS (covers 32-bit wrap).
  - On fault: go to RESP directly, rdata=0, no array access.
- BEAT0: counter != 0 → decrement. Counter = 0 → access word w0, then go to BEAT1 (split, counter reloaded) or RESP.
  - Store byte mask = ((1<<nbytes)-1) << off, low 4 bits; data = wdata << 8*off.
  - Load latches the word as lo.
- BEAT1: same count-then-access on w1.
  - Store mask = ((1<<nbytes)-1) >> (4-off); data = wdata >> 8*(4-off).
  - Load latches hi.
- RESP: done=1; rdata = extend(({hi,lo} >> 8*off)[nbytes*8-1:0]). Sign extension for LB/LH, zero extension for LBU/LHU/LW. Return to IDLE.
- req is ignored while busy, including RESP; a request held high across RESP is accepted in the following IDLE cycle.
- Array is not cleared by reset and is never written on a load or a faulted request.

## Timing
- Reset values: state=IDLE, busy=0, done=0, fault=0, rdata=0, counter=0.
- req accepted at the edge ending cycle T.
  - Aligned: access at edge ending T+1+LATENCY; done in cycle T+2+LATENCY.
  - Split: beat1 at edge ending T+2+2·LATENCY; done in cycle T+3+2·LATENCY.
  - Fault: done=fault=1 in cycle T+1.
- LATENCY=0: aligned done in T+2, split in T+3.
- Peak throughput is one aligned access per LATENCY+3 cycles (IDLE, BEAT0 wait/access, RESP).
- Reset mid-operation: state returns to IDLE at the next edge. Bytes already committed by a completed beat0 of a split store remain written; beat1 is dropped. No done is issued.
- reset has priority over req in the same cycle.

## Test plan
- LATENCY=1. Store word 0x8899AABB at 0x10, then LW 0x10 → rdata=0x8899AABB. Done 3 cycles after each accept; fault=0.
- LB 0x13 → 0xFFFFFF88; LBU 0x13 → 0x00000088; LH 0x12 → 0xFFFF8899; LHU 0x10 → 0x0000AABB.
- Misaligned: SW 0x11223344 at 0x22, then LW 0x22 → 0x11223344. Words 0x20/0x24 show bytes 0x3344 in upper half and 0x1122 in lower half, neighbours untouched. Done at T+5 (split, LATENCY=1).
- Faults, each giving done=fault=1 at T+1, rdata=0, and memory unchanged:
  - mem_size=11;
  - load with mem_extend=011;
  - addr=4*DEPTH_WORDS;
  - LW at 4*DEPTH_WORDS-2.
- req held high continuously with back-to-back LBs → each accepted only in IDLE. No request is lost or duplicated; busy is low exactly one cycle between transactions.
- reset asserted in BEAT1 of a split SW → beat0 bytes persist, beat1 bytes unchanged, no done. Outputs are at reset values next cycle, and a new request then completes normally.

Source files
------------

// File: rtl/data_mem_responder_if.sv
// Load/store request bus between the control unit (master) and the data
// memory responder (slave).
//   req/we/addr/wdata/mem_size/mem_extend : request, driven by the master
//   busy/done/rdata/fault                 : status and response, driven by the slave
interface data_mem_responder_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [1:0]  mem_size;
  logic [2:0]  mem_extend;
  logic        busy;
  logic        done;
  logic [31:0] rdata;
  logic        fault;

  modport master (
    output req, we, addr, wdata, mem_size, mem_extend,
    input  busy, done, rdata, fault
  );

  modport slave (
    input  req, we, addr, wdata, mem_size, mem_extend,
    output busy, done, rdata, fault
  );
endinterface

// File: rtl/data_mem_responder.sv
// Data-memory responder for the RV32I core. Accepts one byte/half/word load
// or store per handshake and performs it on an internal little-endian word
// array. Accesses that straddle a word boundary take two word beats; each
// beat is preceded by LATENCY wait cycles. Loads return sign- or
// zero-extended data on the single-cycle done pulse; fault qualifies done
// for rejected requests, which never touch the array.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-high
//   bus   : slave side of data_mem_responder_if (request in, busy/done/rdata/fault out)
module data_mem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  data_mem_responder_if.slave   bus
);

  localparam int          IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0]  LAT   = 4'(LATENCY);
  localparam logic [31:0] DEPTH = 32'(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_t;

  // Shift the two-word window down to the access offset and extend the
  // requested number of bytes to 32 bits.
  function automatic logic [31:0] load_extend(input logic [63:0] pair,
                                              input logic [1:0]  off,
                                              input logic [2:0]  nb,
                                              input logic        uns);
    logic [63:0] sh;
    logic [31:0] r;
    sh = pair >> {off, 3'b000};
    case (nb)
      3'd1:    r = uns ? {24'b0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
      3'd2:    r = uns ? {16'b0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      default: r = sh[31:0];
    endcase
    return r;
  endfunction

  logic [31:0] mem [DEPTH_WORDS];

  state_t             state;
  logic [3:0]         cnt;
  logic               we_p0;
  logic [1:0]         off_p0;
  logic [2:0]         nb_p0;
  logic               split_p0;
  logic               uns_p0;
  logic [IDX_W-1:0]   w0_p0;
  logic [IDX_W-1:0]   w1_p0;
  logic [31:0]        wdata_p0;
  logic [31:0]        lo_p1;

  // Accept-time decode of the incoming request
  logic [1:0]  acc_off;
  logic [2:0]  acc_nb;
  logic        acc_split;
  logic [29:0] acc_w0;
  logic [30:0] acc_w1;
  logic        acc_bad_ext;
  logic        acc_fault;

  always_comb begin
    acc_off = bus.addr[1:0];
    case (bus.mem_size)
      2'b00:   acc_nb = 3'd1;
      2'b01:   acc_nb = 3'd2;
      default: acc_nb = 3'd4;
    endcase
    acc_split   = ({1'b0, acc_off} + acc_nb) > 3'd4;
    acc_w0      = bus.addr[31:2];
    // One bit wider so the second word of an access at the top of the
    // address space cannot wrap back into range.
    acc_w1      = {1'b0, acc_w0} + 31'd1;
    acc_bad_ext = !(bus.mem_extend inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    acc_fault   = (bus.mem_size == 2'b11)
               || (!bus.we && acc_bad_ext)
               || ({2'b00, acc_w0} >= DEPTH)
               || (acc_split && ({1'b0, acc_w1} >= DEPTH));
  end

  // Beat access: one word per beat, lanes taken from the 8-lane view of the
  // access shifted to its byte offset (low half = word w0, high half = w1).
  logic             access;
  logic [IDX_W-1:0] rd_idx;
  logic [31:0]      rd_word;
  logic [3:0]       nb_mask;
  logic [7:0]       lane_mask;
  logic [63:0]      lane_data;
  logic             wr_en;
  logic [3:0]       wr_mask;
  logic [31:0]      wr_data;

  always_comb begin
    access    = ((state == BEAT0) || (state == BEAT1)) && (cnt == 4'd0) && !reset;
    rd_idx    = (state == BEAT1) ? w1_p0 : w0_p0;
    rd_word   = mem[rd_idx];
    nb_mask   = (nb_p0 == 3'd1) ? 4'b0001 : (nb_p0 == 3'd2) ? 4'b0011 : 4'b1111;
    lane_mask = {4'b0000, nb_mask} << off_p0;
    lane_data = {32'b0, wdata_p0} << {off_p0, 3'b000};
    wr_en     = access && we_p0;
    wr_mask   = (state == BEAT1) ? lane_mask[7:4] : lane_mask[3:0];
    wr_data   = (state == BEAT1) ? lane_data[63:32] : lane_data[31:0];
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_mask[b]) mem[rd_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      bus.busy  <= 1'b0;
      bus.done  <= 1'b0;
      bus.fault <= 1'b0;
      bus.rdata <= 32'b0;
    end else begin
      bus.done  <= 1'b0;
      bus.fault <= 1'b0;
      case (state)
        // Stage boundary: request capture
        IDLE: begin
          if (bus.req) begin
            we_p0    <= bus.we;
            off_p0   <= acc_off;
            nb_p0    <= acc_nb;
            split_p0 <= acc_split;
            uns_p0   <= bus.mem_extend[2];
            w0_p0    <= acc_w0[IDX_W-1:0];
            w1_p0    <= acc_w1[IDX_W-1:0];
            wdata_p0 <= bus.wdata;
            bus.busy <= 1'b1;
            if (acc_fault) begin
              state     <= RESP;
              bus.done  <= 1'b1;
              bus.fault <= 1'b1;
              bus.rdata <= 32'b0;
            end else begin
              state <= BEAT0;
              cnt   <= LAT;
            end
          end
        end
        // Stage boundary: first word beat
        BEAT0: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else if (split_p0) begin
            state <= BEAT1;
            cnt   <= LAT;
            lo_p1 <= rd_word;
          end else begin
            state     <= RESP;
            bus.done  <= 1'b1;
            bus.rdata <= we_p0 ? 32'b0 : load_extend({32'b0, rd_word}, off_p0, nb_p0, uns_p0);
          end
        end
        // Stage boundary: second word beat of a split access
        BEAT1: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            state     <= RESP;
            bus.done  <= 1'b1;
            bus.rdata <= we_p0 ? 32'b0 : load_extend({rd_word, lo_p1}, off_p0, nb_p0, uns_p0);
          end
        end
        // Stage boundary: response cycle, done is high here
        default: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;
  localparam int DEPTH = 1024;
  localparam int LAT   = 1;
  localparam int NBYTE = 4 * DEPTH;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  data_mem_responder_if bus();

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int done_count = 0;

  // ---------------- behavioural model ----------------
  typedef struct { int cyc; int a; logic [7:0] d; } wr_t;
  logic [7:0]  mm [NBYTE];
  wr_t         pend[$];
  int          busy_until  = 0;
  int          exp_done_cyc = -1;
  logic        exp_fault   = 1'b0;
  logic        exp_is_load = 1'b0;
  logic [31:0] exp_rdata   = 32'b0;
  int          last_reset  = -10;

  initial for (int i = 0; i < NBYTE; i++) mm[i] = 8'h00;

  always @(posedge clk) begin
    int nb;
    logic flt;
    logic [32:0] last;
    logic [31:0] v;
    if (reset) begin
      pend.delete();
      busy_until   = cyc;
      exp_done_cyc = -1;
      last_reset   = cyc;
    end else begin
      for (int i = pend.size() - 1; i >= 0; i--) begin
        if (pend[i].cyc == cyc) begin
          mm[pend[i].a] = pend[i].d;
          pend.delete(i);
        end
      end
      if (bus.req && cyc > busy_until) begin
        nb   = (bus.mem_size == 2'd0) ? 1 : (bus.mem_size == 2'd1) ? 2 : 4;
        last = {1'b0, bus.addr} + 33'(nb - 1);
        flt  = (bus.mem_size == 2'b11) || (last >= 33'(NBYTE)) ||
               (!bus.we && !(bus.mem_extend == 3'd0 || bus.mem_extend == 3'd1 ||
                             bus.mem_extend == 3'd2 || bus.mem_extend == 3'd4 ||
                             bus.mem_extend == 3'd5));
        exp_fault   = flt;
        exp_is_load = !bus.we;
        exp_rdata   = 32'b0;
        if (flt) begin
          exp_done_cyc = cyc + 1;
        end else begin
          if (int'(bus.addr[1:0]) + nb > 4) exp_done_cyc = cyc + 3 + 2 * LAT;
          else                              exp_done_cyc = cyc + 2 + LAT;
          if (bus.we) begin
            for (int i = 0; i < nb; i++) begin
              int ba;
              wr_t w;
              ba = int'(bus.addr) + i;
              w.a = ba;
              w.d = bus.wdata[8*i +: 8];
              w.cyc = ((ba >> 2) == int'(bus.addr >> 2)) ? cyc + 1 + LAT : cyc + 2 + 2 * LAT;
              pend.push_back(w);
            end
          end else begin
            v = 32'b0;
            for (int i = 0; i < nb; i++) v[8*i +: 8] = mm[int'(bus.addr) + i];
            if (!bus.mem_extend[2] && nb == 1) v = {{24{v[7]}}, v[7:0]};
            if (!bus.mem_extend[2] && nb == 2) v = {{16{v[15]}}, v[15:0]};
            exp_rdata = v;
          end
        end
        busy_until = exp_done_cyc;
      end
    end
    cyc = cyc + 1;
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (cyc >= 1) begin
      logic eb, ed;
      eb = (cyc <= busy_until);
      ed = (cyc == exp_done_cyc);
      n_checks++;
      if (bus.busy !== eb) begin
        n_fail++;
        $display("FAIL busy cyc=%0d got=%b want=%b", cyc, bus.busy, eb);
      end
      n_checks++;
      if (bus.done !== ed) begin
        n_fail++;
        $display("FAIL done cyc=%0d got=%b want=%b", cyc, bus.done, ed);
      end
      if (bus.done === 1'b1) done_count++;
      if (ed && bus.done === 1'b1) begin
        n_checks++;
        if (bus.fault !== exp_fault) begin
          n_fail++;
          $display("FAIL fault cyc=%0d got=%b want=%b", cyc, bus.fault, exp_fault);
        end
        if (exp_fault || exp_is_load) begin
          n_checks++;
          if (bus.rdata !== exp_rdata) begin
            n_fail++;
            $display("FAIL rdata cyc=%0d got=%h want=%h", cyc, bus.rdata, exp_rdata);
          end
        end
      end
      if (cyc == last_reset + 1) begin
        n_checks++;
        if (bus.rdata !== 32'b0 || bus.fault !== 1'b0) begin
          n_fail++;
          $display("FAIL reset_out cyc=%0d rdata=%h fault=%b want 0/0", cyc, bus.rdata, bus.fault);
        end
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    while (bus.busy !== 1'b0 && g < 50) begin
      @(negedge clk);
      g++;
    end
    if (bus.busy !== 1'b0) begin
      n_checks++;
      n_fail++;
      $display("FAIL idle_timeout cyc=%0d busy=%b want 0", cyc, bus.busy);
    end
  endtask

  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [2:0] f3, output logic [31:0] rd,
                       output logic flt, output int lat);
    int t;
    @(negedge clk);
    wait_idle();
    bus.req = 1'b1; bus.we = w; bus.addr = a; bus.wdata = d;
    bus.mem_size = f3[1:0]; bus.mem_extend = f3;
    t = cyc;
    @(negedge clk);
    bus.req = 1'b0;
    lat = -1; rd = 32'b0; flt = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (bus.done === 1'b1) begin
        rd = bus.rdata; flt = bus.fault; lat = cyc - t;
        break;
      end
      @(negedge clk);
    end
    if (lat < 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL done_timeout addr=%h got no done want done", a);
    end
  endtask

  // op: run and check result, fault and latency against literals
  task automatic op_chk(input string name, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [2:0] f3,
                        input logic [31:0] exp_rd, input logic exp_f, input int exp_lat);
    logic [31:0] rd; logic flt; int lat;
    issue(w, a, d, f3, rd, flt, lat);
    if (!w || exp_f) chk({name, "_rdata"}, rd, exp_rd);
    chk({name, "_fault"}, 32'(flt), 32'(exp_f));
    chk({name, "_lat"}, 32'(lat), 32'(exp_lat));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog cyc=%0d got no end want end", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] rd; logic flt; int lat;
    int tacc[6];
    int t, d0;
    bus.req = 1'b0; bus.we = 1'b0; bus.addr = 32'b0; bus.wdata = 32'b0;
    bus.mem_size = 2'b0; bus.mem_extend = 3'b0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_busy",  32'(bus.busy),  32'd0);
    chk("rst_done",  32'(bus.done),  32'd0);
    chk("rst_fault", 32'(bus.fault), 32'd0);
    chk("rst_rdata", bus.rdata, 32'd0);

    // Known contents for the low and top regions
    for (int i = 0; i < 64; i++) issue(1'b1, 32'(4 * i), $urandom, 3'b010, rd, flt, lat);
    for (int i = DEPTH - 8; i < DEPTH; i++) issue(1'b1, 32'(4 * i), $urandom, 3'b010, rd, flt, lat);

    // Aligned store/load and sub-word extension
    op_chk("sw10",  1'b1, 32'h10, 32'h8899AABB, 3'b010, 32'h0, 1'b0, 3);
    op_chk("lw10",  1'b0, 32'h10, 32'h0, 3'b010, 32'h8899AABB, 1'b0, 3);
    op_chk("lb13",  1'b0, 32'h13, 32'h0, 3'b000, 32'hFFFFFF88, 1'b0, 3);
    op_chk("lbu13", 1'b0, 32'h13, 32'h0, 3'b100, 32'h00000088, 1'b0, 3);
    op_chk("lh12",  1'b0, 32'h12, 32'h0, 3'b001, 32'hFFFF8899, 1'b0, 3);
    op_chk("lhu10", 1'b0, 32'h10, 32'h0, 3'b101, 32'h0000AABB, 1'b0, 3);

    // Misaligned word store across 0x20/0x24
    op_chk("sw1c", 1'b1, 32'h1C, 32'h01020304, 3'b010, 32'h0, 1'b0, 3);
    op_chk("sw20", 1'b1, 32'h20, 32'h55667788, 3'b010, 32'h0, 1'b0, 3);
    op_chk("sw24", 1'b1, 32'h24, 32'h99AABBCC, 3'b010, 32'h0, 1'b0, 3);
    op_chk("sw28", 1'b1, 32'h28, 32'h0A0B0C0D, 3'b010, 32'h0, 1'b0, 3);
    op_chk("sw22", 1'b1, 32'h22, 32'h11223344, 3'b010, 32'h0, 1'b0, 5);
    op_chk("lw22", 1'b0, 32'h22, 32'h0, 3'b010, 32'h11223344, 1'b0, 5);
    op_chk("lw20", 1'b0, 32'h20, 32'h0, 3'b010, 32'h33447788, 1'b0, 3);
    op_chk("lw24", 1'b0, 32'h24, 32'h0, 3'b010, 32'h99AA1122, 1'b0, 3);
    op_chk("lw1c", 1'b0, 32'h1C, 32'h0, 3'b010, 32'h01020304, 1'b0, 3);
    op_chk("lw28", 1'b0, 32'h28, 32'h0, 3'b010, 32'h0A0B0C0D, 1'b0, 3);

    // Faults: no memory effect, done+fault one cycle after accept
    op_chk("f_size",  1'b1, 32'h10, 32'hFFFFFFFF, 3'b011, 32'h0, 1'b1, 1);
    op_chk("f_ext",   1'b0, 32'h10, 32'h0, 3'b011, 32'h0, 1'b1, 1);
    op_chk("f_ext6",  1'b0, 32'h10, 32'h0, 3'b110, 32'h0, 1'b1, 1);
    op_chk("f_top",   1'b0, 32'(NBYTE), 32'h0, 3'b010, 32'h0, 1'b1, 1);
    op_chk("f_topst", 1'b1, 32'(NBYTE), 32'h12345678, 3'b000, 32'h0, 1'b1, 1);
    op_chk("f_split", 1'b0, 32'(NBYTE - 2), 32'h0, 3'b010, 32'h0, 1'b1, 1);
    op_chk("f_wrap",  1'b1, 32'hFFFFFFFE, 32'h0, 3'b010, 32'h0, 1'b1, 1);
    op_chk("lw10b",   1'b0, 32'h10, 32'h0, 3'b010, 32'h8899AABB, 1'b0, 3);
    op_chk("sw_last", 1'b1, 32'(NBYTE - 4), 32'hCAFEF00D, 3'b010, 32'h0, 1'b0, 3);
    op_chk("lhu_hi",  1'b0, 32'(NBYTE - 2), 32'h0, 3'b101, 32'h0000CAFE, 1'b0, 3);

    // req held high: back-to-back LBs accepted only in IDLE
    @(negedge clk);
    wait_idle();
    d0 = done_count;
    bus.req = 1'b1; bus.we = 1'b0; bus.mem_size = 2'b00; bus.mem_extend = 3'b000;
    bus.addr = 32'($urandom_range(0, 255));
    for (int k = 0; k < 6; k++) begin
      wait_idle();
      tacc[k] = cyc;
      @(negedge clk);
      if (k == 5) bus.req = 1'b0;
      else        bus.addr = 32'($urandom_range(0, 255));
    end
    repeat (8) @(negedge clk);
    chk("b2b_count", 32'(done_count - d0), 32'd6);
    for (int k = 1; k < 6; k++) chk("b2b_gap", 32'(tacc[k] - tacc[k-1]), 32'(LAT + 3));

    // Reset during BEAT1 of a split store
    op_chk("sw30", 1'b1, 32'h30, 32'hA0A1A2A3, 3'b010, 32'h0, 1'b0, 3);
    op_chk("sw34", 1'b1, 32'h34, 32'hB0B1B2B3, 3'b010, 32'h0, 1'b0, 3);
    @(negedge clk);
    wait_idle();
    bus.req = 1'b1; bus.we = 1'b1; bus.addr = 32'h31; bus.wdata = 32'hDEADBEEF;
    bus.mem_size = 2'b10; bus.mem_extend = 3'b010;
    t = cyc;
    @(negedge clk);
    bus.req = 1'b0;
    while (cyc < t + 3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mid_busy",  32'(bus.busy),  32'd0);
    chk("mid_done",  32'(bus.done),  32'd0);
    chk("mid_fault", 32'(bus.fault), 32'd0);
    chk("mid_rdata", bus.rdata, 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("mid_nodone", 32'(bus.done), 32'd0);
    end
    op_chk("lw30", 1'b0, 32'h30, 32'h0, 3'b010, 32'hADBEEFA3, 1'b0, 3);
    op_chk("lw34", 1'b0, 32'h34, 32'h0, 3'b010, 32'hB0B1B2B3, 1'b0, 3);

    // Randomized traffic checked by the model
    for (int n = 0; n < 300; n++) begin
      logic [31:0] a;
      int r;
      r = $urandom_range(0, 99);
      if (r < 70)      a = 32'($urandom_range(0, 251));
      else if (r < 95) a = 32'(NBYTE - 32 + $urandom_range(0, 31));
      else if (r < 98) a = 32'(NBYTE + $urandom_range(0, 64));
      else             a = 32'hFFFFFFFC + 32'($urandom_range(0, 3));
      issue(1'($urandom_range(0, 1)), a, $urandom, 3'($urandom_range(0, 7)), rd, flt, lat);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
